// File: rtl/vmem_seq.sv
// vmem_seq: splits vector memory instructions into lane-wide beats and buffers load returns
module vmem_seq #(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 32,
  parameter int VCWIDTH      = 32,
  parameter int MEMDEPTH     = 2048,
  parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [6:0]                       req_op,
  input  logic [LOGMEMDEPTH-1:0]           req_base,
  input  logic [VCWIDTH-1:0]               req_stride,
  input  logic [VCWIDTH-1:0]               req_vl,
  input  logic                             st_valid,
  output logic                             st_ready,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] st_data,
  output logic                             ld_valid,
  input  logic                             ld_ready,
  output logic [NUMLANES*DATAWORDSIZE-1:0] ld_data,
  output logic [NUMLANES-1:0]              ld_mask,
  output logic                             ld_last,
  output logic                             done,
  output logic                             done_err,
  output logic [6:0]                       mem_op,
  output logic [LOGMEMDEPTH-1:0]           mem_address,
  output logic [VCWIDTH-1:0]               mem_stride,
  output logic [NUMLANES-1:0]              mem_en,
  output logic [NUMLANES*DATAWORDSIZE-1:0] mem_data,
  input  logic [NUMLANES*DATAWORDSIZE-1:0] mem_out
);
  localparam int W = NUMLANES*DATAWORDSIZE;
  typedef enum logic [2:0] {IDLE, LOAD, STORE, DRAIN, DONE} state_t;
  state_t                 state_q, state_d;
  logic [6:0]             op_q, op_d;
  logic [LOGMEMDEPTH-1:0] addr_q, addr_d, step;
  logic [VCWIDTH-1:0]     stride_q, stride_d, rem_q, rem_d;
  logic                   err_q, err_d, infl_q, infl_d, infl_last_q, infl_last_d;
  logic [NUMLANES-1:0]    infl_mask_q, infl_mask_d, mask;
  logic [W-1:0]           fd_q [2];
  logic [W-1:0]           fd_d [2];
  logic [NUMLANES-1:0]    fm_q [2];
  logic [NUMLANES-1:0]    fm_d [2];
  logic [1:0]             fl_q, fl_d, cnt_q, cnt_d;
  logic                   wp_q, wp_d, rp_q, rp_d;
  logic                   last, pop, issue, bad_op;
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUMLANES; i++) mask[i] = rem_q > VCWIDTH'(i);
    last = rem_q <= VCWIDTH'(NUMLANES);
    pop = (cnt_q != 2'd0) && ld_ready;
    // occupancy counts the beat whose read data is still on its way back
    issue = state_q == STORE ? st_valid :
            state_q == LOAD && ({1'b0, cnt_q} + {2'b0, infl_q} < 3'd2 + {2'b0, pop});
    step = op_q[5:4] == 2'b01 ? LOGMEMDEPTH'(stride_q * VCWIDTH'(NUMLANES)) : LOGMEMDEPTH'(NUMLANES);
    bad_op = !req_op[6] || req_op[5];
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    stride_d = stride_q;
    rem_d = rem_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d = req_op;
        addr_d = req_base;
        stride_d = req_stride;
        rem_d = req_vl;
        err_d = bad_op;
        state_d = bad_op || req_vl == '0 ? DONE : req_op[0] ? STORE : LOAD;
      end
      LOAD, STORE: if (issue) begin
        addr_d = addr_q + step;
        rem_d = last ? '0 : rem_q - VCWIDTH'(NUMLANES);
        if (last) state_d = state_q == LOAD ? DRAIN : DONE;
      end
      DRAIN: if (pop && fl_q[rp_q]) state_d = DONE;
      default: state_d = IDLE;
    endcase
    infl_d = issue && state_q == LOAD;
    infl_mask_d = mask;
    infl_last_d = last;
    fd_d = fd_q;
    fm_d = fm_q;
    fl_d = fl_q;
    wp_d = wp_q ^ infl_q;
    rp_d = rp_q ^ pop;
    if (infl_q) begin
      fd_d[wp_q] = mem_out;
      fm_d[wp_q] = infl_mask_q;
      fl_d[wp_q] = infl_last_q;
    end
    cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      stride_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
      infl_q <= 1'b0;
      infl_mask_q <= '0;
      infl_last_q <= 1'b0;
      fd_q <= '{default: '0};
      fm_q <= '{default: '0};
      fl_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      stride_q <= stride_d;
      rem_q <= rem_d;
      err_q <= err_d;
      infl_q <= infl_d;
      infl_mask_q <= infl_mask_d;
      infl_last_q <= infl_last_d;
      fd_q <= fd_d;
      fm_q <= fm_d;
      fl_q <= fl_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign st_ready = state_q == STORE && st_valid;
  assign ld_valid = cnt_q != 2'd0;
  assign ld_data = ld_valid ? fd_q[rp_q] : '0;
  assign ld_mask = ld_valid ? fm_q[rp_q] : '0;
  assign ld_last = ld_valid && fl_q[rp_q];
  assign done = state_q == DONE;
  assign done_err = done && err_q;
  assign mem_op = issue ? op_q : '0;
  assign mem_address = issue ? addr_q : '0;
  assign mem_stride = stride_q;
  assign mem_en = issue ? mask : '0;
  assign mem_data = st_ready ? st_data : '0;
endmodule

// File: tb/tb_vmem_seq.sv
// tb_vmem_seq: directed vectors for vmem_seq with a behavioural lane memory
module tb_vmem_seq;
  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic [6:0]   req_op = '0;
  logic [10:0]  req_base = '0;
  logic [31:0]  req_stride = '0, req_vl = '0;
  logic         st_valid = 1'b0, st_ready;
  logic [255:0] st_data = '0;
  logic         ld_valid, ld_ready = 1'b0, ld_last;
  logic [255:0] ld_data, mem_data, mem_out = '0;
  logic [7:0]   ld_mask, mem_en;
  logic         done, done_err;
  logic [6:0]   mem_op;
  logic [10:0]  mem_address;
  logic [31:0]  mem_stride;
  vmem_seq dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_mask(ld_mask),
    .ld_last(ld_last), .done(done), .done_err(done_err), .mem_op(mem_op),
    .mem_address(mem_address), .mem_stride(mem_stride), .mem_en(mem_en),
    .mem_data(mem_data), .mem_out(mem_out)
  );
  always #5 clk = ~clk;
  int nvec = 0, nerr = 0, cyc = 0, t0 = 0, done_cyc = -1, nst = 0;
  logic done_err_s = 1'b0;
  logic [10:0]  iss_addr [$];
  logic [7:0]   iss_en [$];
  logic [6:0]   iss_op [$];
  logic [31:0]  iss_stride [$];
  int           iss_cyc [$];
  logic [255:0] pop_data [$];
  logic [7:0]   pop_mask [$];
  logic         pop_last [$];
  int           pop_cyc [$];
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] beat(input logic [10:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'h5A000000 + 32'(a) * 32'd16 + 32'(i);
    return r;
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en != 8'h0 && !mem_op[0]) mem_out <= beat(mem_address);
  end
  always @(negedge clk) begin
    if (mem_en != 8'h0) begin
      iss_addr.push_back(mem_address);
      iss_en.push_back(mem_en);
      iss_op.push_back(mem_op);
      iss_stride.push_back(mem_stride);
      iss_cyc.push_back(cyc);
      if (mem_op[0]) begin
        check("st_ready_on_issue", st_ready, 1'b1);
        check("mem_data", mem_data, st_data);
      end
    end
    if (st_ready) nst++;
    if (ld_valid && ld_ready) begin
      pop_data.push_back(ld_data);
      pop_mask.push_back(ld_mask);
      pop_last.push_back(ld_last);
      pop_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc = cyc;
      done_err_s = done_err;
    end
  end
  task automatic req(input logic [6:0] op, input logic [10:0] base, input logic [31:0] stride, input logic [31:0] vl);
    iss_addr.delete(); iss_en.delete(); iss_op.delete(); iss_stride.delete(); iss_cyc.delete();
    pop_data.delete(); pop_mask.delete(); pop_last.delete(); pop_cyc.delete();
    done_cyc = -1;
    nst = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_base = base; req_stride = stride; req_vl = vl;
    @(negedge clk); #1;
    check("req_ready", req_ready, 1'b1);
    t0 = cyc;
  endtask
  task automatic run(input int maxc, input bit tog, input int hold);
    bit got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      ld_ready = i >= hold;
      if (tog) begin
        st_valid = ~st_valid;
        st_data = {8{$urandom}};
      end
      @(negedge clk); #1;
      if (i == hold - 1) begin
        check("stall_issues", iss_addr.size(), 2);
        check("stall_pops", pop_data.size(), 0);
        check("stall_ld_valid", ld_valid, 1'b1);
      end
      got = done;
    end
    check("done_seen", got, 1'b1);
    st_valid = 1'b0;
  endtask
  task automatic verify(input logic [10:0] base, input int step, input int vl, input bit ld);
    int nb;
    nb = (vl + 7) / 8;
    check("n_issue", iss_addr.size(), nb);
    if (ld) check("n_pop", pop_data.size(), nb);
    for (int b = 0; b < nb && b < iss_addr.size(); b++) begin
      logic [10:0] a;
      logic [7:0]  m;
      int          r;
      a = base + 11'(b * step);
      r = vl - 8 * b;
      m = r >= 8 ? 8'hFF : 8'((1 << r) - 1);
      check("addr", iss_addr[b], a);
      check("en", iss_en[b], m);
      if (ld && b < pop_data.size()) begin
        check("ld_data", pop_data[b], beat(a));
        check("ld_mask", pop_mask[b], m);
        check("ld_last", pop_last[b], b == nb - 1);
      end
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    #2 resetn = 1'b0;
    #20;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_ld_valid", ld_valid, 1'b0);
    check("rst_mem_en", mem_en, 8'h0);
    check("rst_mem_op", mem_op, 7'h0);
    check("rst_done", {done, done_err, st_ready}, 3'b0);
    check("rst_mem_stride", mem_stride, 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    // unit-stride load, partial final beat
    req(7'h48, 11'd10, 32'd0, 32'd20);
    run(50, 1'b0, 0);
    verify(11'd10, 8, 20, 1'b1);
    check("t1_addr2", iss_addr.size() == 3 ? iss_addr[2] : 11'h7FF, 11'd26);
    check("t1_mask2", iss_en.size() == 3 ? iss_en[2] : 8'h0, 8'h0F);
    check("t1_op", iss_op.size() > 0 ? iss_op[0] : 7'h0, 7'h48);
    check("t1_issue_cyc", iss_cyc.size() > 0 ? iss_cyc[0] - t0 : -1, 1);
    check("t1_first_pop", pop_cyc.size() > 0 ? pop_cyc[0] - t0 : -1, 3);
    check("t1_done_cyc", done_cyc - t0, 6);
    check("t1_done_err", done_err_s, 1'b0);
    // strided store with st_valid toggling
    req(7'h59, 11'd100, 32'd3, 32'd16);
    run(50, 1'b1, 0);
    verify(11'd100, 24, 16, 1'b0);
    check("t2_stride", iss_stride.size() > 0 ? iss_stride[0] : 32'h0, 32'd3);
    check("t2_st_ready_cnt", nst, 2);
    check("t2_done_cyc", done_cyc - t0, 4);
    check("t2_done_err", done_err_s, 1'b0);
    // backpressured long load
    req(7'h48, 11'd512, 32'd0, 32'd64);
    run(200, 1'b0, 10);
    verify(11'd512, 8, 64, 1'b1);
    check("t3_done_err", done_err_s, 1'b0);
    // address wrap
    req(7'h48, 11'd2044, 32'd0, 32'd16);
    run(50, 1'b0, 0);
    verify(11'd2044, 8, 16, 1'b1);
    check("t4_wrap_addr", iss_addr.size() > 1 ? iss_addr[1] : 11'h7FF, 11'd4);
    // indexed, memop=0, vl=0
    req(7'h68, 11'd0, 32'd0, 32'd8);
    run(10, 1'b0, 0);
    check("t5_idx_done_cyc", done_cyc - t0, 1);
    check("t5_idx_err", done_err_s, 1'b1);
    check("t5_idx_issues", iss_addr.size(), 0);
    req(7'h08, 11'd0, 32'd0, 32'd8);
    run(10, 1'b0, 0);
    check("t5_nomem_done_cyc", done_cyc - t0, 1);
    check("t5_nomem_err", done_err_s, 1'b1);
    check("t5_nomem_issues", iss_addr.size(), 0);
    req(7'h48, 11'd0, 32'd0, 32'd0);
    run(10, 1'b0, 0);
    check("t5_vl0_done_cyc", done_cyc - t0, 1);
    check("t5_vl0_err", done_err_s, 1'b0);
    check("t5_vl0_issues", iss_addr.size(), 0);
    // reset with the load buffer full
    req(7'h48, 11'd0, 32'd0, 32'd64);
    @(posedge clk); #1 req_valid = 1'b0; ld_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("t6_pre_ld_valid", ld_valid, 1'b1);
    resetn = 1'b0;
    #1;
    check("t6_req_ready", req_ready, 1'b1);
    check("t6_ld_valid", ld_valid, 1'b0);
    check("t6_ld_data", ld_data, 256'h0);
    check("t6_mem_en", mem_en, 8'h0);
    check("t6_outs", {done, done_err, st_ready, mem_op}, 10'h0);
    @(posedge clk); #1 resetn = 1'b1;
    req(7'h48, 11'd40, 32'd0, 32'd12);
    run(50, 1'b0, 0);
    verify(11'd40, 8, 12, 1'b1);
    check("t6_done_cyc", done_cyc - t0, 5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/vmem_seq.md
# vmem_seq

Vector memory sequencer sitting directly upstream of the per-lane local vector memory. It accepts one vector memory instruction at a time (op, base, stride, vector length), splits it into NUMLANES-wide beats, and drives the memory's port A with per-beat address, lane enables and store data. It returns load results through a small credit-limited buffer with a valid/ready handshake, and pulses `done` when the instruction retires.

## Interface
- `NUMLANES`, 8, lanes per beat
- `DATAWORDSIZE`, 32, bits per lane word
- `VCWIDTH`, 32, width of stride and vector length
- `MEMDEPTH`, 2048, words per lane memory
- `LOGMEMDEPTH`, $clog2(MEMDEPTH), address width
- `clk` in 1: the single clock
- `resetn` in 1: asynchronous, active-low reset
- `req_valid` in 1: instruction offered
- `req_ready` out 1: high only in IDLE
- `req_op` in 7: {memop, pattern[1:0], size[1:0], signed, we}
- `req_base` in LOGMEMDEPTH: base address
- `req_stride` in VCWIDTH: element stride, used only for pattern 01
- `req_vl` in VCWIDTH: vector length in elements
- `st_valid` in 1: store beat data offered
- `st_ready` out 1: store beat consumed
- `st_data` in NUMLANES*DATAWORDSIZE: store beat data
- `ld_valid` out 1: load beat available
- `ld_ready` in 1: consumer accepts load beat
- `ld_data` out NUMLANES*DATAWORDSIZE: load beat data
- `ld_mask` out NUMLANES: valid lanes of the load beat
- `ld_last` out 1: final beat of the instruction
- `done` out 1: one-cycle retire pulse
- `done_err` out 1: qualifies `done`; op was not executed
- `mem_op` out 7: op sent to memory; 0 on idle cycles
- `mem_address` out LOGMEMDEPTH: beat base address
- `mem_stride` out VCWIDTH: captured stride
- `mem_en` out NUMLANES: lane enables
- `mem_data` out NUMLANES*DATAWORDSIZE: store data to memory
- `mem_out` in NUMLANES*DATAWORDSIZE: read data, valid 1 cycle after issue

## Operation
- States: IDLE, LOAD, STORE, DRAIN, DONE. Each accept is `req_valid & req_ready`.
- On accept, capture op, base, stride and vl. Set beats = ceil(vl/NUMLANES) and rem = vl.
- Next state on accept:
  - memop=0 or pattern[1]=1: go to DONE with err=1. No memory access.
  - vl=0: go to DONE with err=0.
  - we=1: go to STORE.
  - we=0: go to LOAD.
- Lane mask for each beat: lane i is enabled iff i < min(rem, NUMLANES).
- Issue cycle outputs: `mem_op`=captured op, `mem_en`=mask, current address. After the beat, address += NUMLANES*stride for pattern 01, or += NUMLANES for pattern 00. Addresses are truncated to LOGMEMDEPTH and wrap modulo MEMDEPTH. rem -= NUMLANES, saturating at 0.
- Non-issue cycles drive `mem_op`=0 and `mem_en`=0.
- STORE: a beat issues in any cycle with `st_valid`, and `st_ready` is high in that cycle. `mem_data`=`st_data`. After the last beat issues, go to DONE.
- LOAD: a 2-entry FIFO holds {data, mask, last}. Issue a beat iff count + inflight − pop < 2, where pop = `ld_valid & ld_ready`.
  - `mem_out` is written into the FIFO the cycle after issue, together with that beat's mask and last flag.
  - After the last beat issues, go to DRAIN.
- DRAIN: once the last beat is popped, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `ld_valid` = FIFO not empty. `ld_data`, `ld_mask` and `ld_last` come from the FIFO head.

## Timing
- Reset: all outputs 0, except `req_ready`=1 (IDLE). FIFO and inflight are cleared.
- Reset mid-operation: abort immediately, drop in-flight read data, no `done`.
- Accept at cycle T → first beat issued at T+1.
- Load data:
  - Beat issued at t is captured at end of t+1.
  - `ld_valid` is asserted earliest at t+2. There is no bypass.
- With `ld_ready` held at 1, loads sustain one beat per cycle.
- Store latency: with `st_valid` held at 1, a B-beat store issues beats T+1..T+B, and `done` fires at T+B+1.
- Load latency: the last beat popped at cycle P gives `done` at P+1.
- `ld_*` and `st_data` must stay stable under backpressure.
- Simultaneous push and pop on a full FIFO is legal.

## Test plan
- Unit load, base=10, vl=20, `ld_ready`=1 → beats at addresses 10, 18, 26. Masks are FF, FF, 0F, and `ld_last` is set on the third beat. `done`=1 and `done_err`=0, 1 cycle after the last pop.
- Strided store, base=100, stride=3, vl=16 with `st_valid` toggling every other cycle → 2 beats at addresses 100 and 124, `mem_stride`=3. Each `st_ready` coincides with a beat, and `mem_en`=FF both times.
- Load with `ld_ready`=0 for 10 cycles, vl=64 → at most 2 beats in flight or buffered, no data lost. After release, 8 beats come out in order.
- Wrap-around: unit load at base=2044, vl=16 → second beat address is 4 (2052 mod 2048).
- Indexed op (pattern 10) or memop=0 → no `mem_en` activity, `done` with `done_err`=1 at T+1. vl=0 → `done` with `done_err`=0 at T+1.
- `resetn` asserted mid-load with FIFO full → all outputs return to 0 immediately and `req_ready`=1. A fresh request afterwards runs correctly.
